// File: rtl/monitor_pager.sv
// Register-monitor pager: registers a flattened CHANNELS x WIDTH monitor bus and
// presents one PAGE-wide window of it, with manual/timed paging and a freeze snapshot.
module monitor_pager #(
  parameter  int CHANNELS = 16,
  parameter  int WIDTH    = 8,
  parameter  int PAGE     = 8,
  parameter  int SCAN_DIV = 50_000_000,
  localparam int NPAGES   = (CHANNELS + PAGE - 1) / PAGE,
  localparam int PIW      = (NPAGES > 1) ? $clog2(NPAGES) : 1,
  localparam int SCW      = $clog2(SCAN_DIV)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] mon_flat,
  input  logic [1:0]                mode,
  input  logic                      snap,
  input  logic                      page_next,
  output logic [PAGE*WIDTH-1:0]     page_out,
  output logic [PIW-1:0]            page_idx,
  output logic [PAGE-1:0]           changed,
  output logic                      snap_valid
);

  localparam int CW    = CHANNELS * WIDTH;
  localparam int NSLOT = NPAGES * PAGE;

  logic [CW-1:0]         live_q, live_d;
  logic [CW-1:0]         snap_q, snap_d;
  logic                  snap_valid_q, snap_valid_d;
  logic [1:0]            mode_q, mode_d;
  logic [PIW-1:0]        page_idx_q, page_idx_d;
  logic [SCW-1:0]        sc_q, sc_d;
  logic [PAGE*WIDTH-1:0] page_out_q, page_out_d;
  logic [PAGE-1:0]       changed_q, changed_d;

  logic                  freeze;
  logic                  capture;
  logic [PIW-1:0]        adv_idx;
  logic [NSLOT*WIDTH-1:0] live_pad, snap_pad, src_pad;
  logic [NSLOT-1:0]      diff_pad;
  int                    base;

  // Capture on an explicit snap pulse or on the first cycle of freeze; both together capture once.
  always_comb begin
    freeze       = (mode == 2'd1);
    capture      = snap | (freeze & (mode_q != 2'd1));
    live_d       = mon_flat;
    mode_d       = mode;
    snap_d       = capture ? mon_flat : snap_q;
    snap_valid_d = snap_valid_q | capture;
  end

  // Paging state: manual pulse wins over the scan timer and both restart the scan period.
  always_comb begin
    adv_idx    = (page_idx_q == PIW'(NPAGES - 1)) ? '0 : page_idx_q + PIW'(1);
    page_idx_d = page_idx_q;
    sc_d       = '0;
    if (page_next) begin
      page_idx_d = adv_idx;
    end else if (mode == 2'd2) begin
      if (sc_q == SCW'(SCAN_DIV - 1)) page_idx_d = adv_idx;
      else                            sc_d       = sc_q + SCW'(1);
    end
  end

  // Channels past CHANNELS are zero padded, so they read 0 and never differ.
  always_comb begin
    live_pad           = '0;
    snap_pad           = '0;
    live_pad[CW-1:0]   = live_q;
    snap_pad[CW-1:0]   = snap_q;
    src_pad            = freeze ? snap_pad : live_pad;
    diff_pad           = '0;
    for (int c = 0; c < NSLOT; c++) begin
      diff_pad[c] = (live_pad[c*WIDTH +: WIDTH] != snap_pad[c*WIDTH +: WIDTH]);
    end
    base       = int'(page_idx_q) * PAGE;
    page_out_d = '0;
    changed_d  = '0;
    for (int i = 0; i < PAGE; i++) begin
      page_out_d[i*WIDTH +: WIDTH] = src_pad[(base + i)*WIDTH +: WIDTH];
      changed_d[i]                 = snap_valid_q & diff_pad[base + i +: 1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q       <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      mode_q       <= 2'd0;
      page_idx_q   <= '0;
      sc_q         <= '0;
      page_out_q   <= '0;
      changed_q    <= '0;
    end else begin
      live_q       <= live_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      mode_q       <= mode_d;
      page_idx_q   <= page_idx_d;
      sc_q         <= sc_d;
      page_out_q   <= page_out_d;
      changed_q    <= changed_d;
    end
  end

  assign page_out   = page_out_q;
  assign page_idx   = page_idx_q;
  assign changed    = changed_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_monitor_pager.sv
// Directed bench for monitor_pager: a 12-channel two-page instance and a 3-channel one-page instance.
module tb_monitor_pager;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [95:0] mon_flat;
  logic [1:0]  mode;
  logic        snap;
  logic        page_next;
  logic [63:0] page_out;
  logic [0:0]  page_idx;
  logic [7:0]  changed;
  logic        snap_valid;

  logic        rst_e;
  logic [23:0] mon_e;
  logic [1:0]  mode_e;
  logic        snap_e;
  logic        page_next_e;
  logic [63:0] page_out_e;
  logic [0:0]  page_idx_e;
  logic [7:0]  changed_e;
  logic        snap_valid_e;

  int total = 0;
  int bad   = 0;

  localparam logic [95:0] BASE  = 96'h1B1A19181716151413121110;
  localparam logic [63:0] PAGE0 = 64'h1716151413121110;
  localparam logic [63:0] PAGE1 = 64'h000000001B1A1918;

  monitor_pager #(.CHANNELS(12), .WIDTH(8), .PAGE(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .mon_flat(mon_flat), .mode(mode), .snap(snap),
    .page_next(page_next), .page_out(page_out), .page_idx(page_idx),
    .changed(changed), .snap_valid(snap_valid)
  );

  monitor_pager #(.CHANNELS(3), .WIDTH(8), .PAGE(8), .SCAN_DIV(4)) dut_e (
    .clk(clk), .rst(rst_e), .mon_flat(mon_e), .mode(mode_e), .snap(snap_e),
    .page_next(page_next_e), .page_out(page_out_e), .page_idx(page_idx_e),
    .changed(changed_e), .snap_valid(snap_valid_e)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT just after its last reset edge (edge 0); the next tick is edge 1.
  task automatic reset_main(input logic [1:0] m);
    rst = 1'b0; mode = m; snap = 1'b0; page_next = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mon_flat = BASE; mode = 2'd1; snap = 1'b1; page_next = 1'b1;
    tick();
    tick();
    total++; if (page_out !== 64'h0) begin bad++; $display("FAIL reset_page_out got=%h want=0", page_out); end
    total++; if (page_idx !== 1'b0) begin bad++; $display("FAIL reset_page_idx got=%h want=0", page_idx); end
    total++; if (changed !== 8'h00) begin bad++; $display("FAIL reset_changed got=%h want=00", changed); end
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL reset_snap_valid got=%b want=0", snap_valid); end
    snap = 1'b0; page_next = 1'b0;
  endtask

  task automatic test_live_paging();
    mon_flat = BASE;
    reset_main(2'd0);
    tick();
    total++; if (page_out !== 64'h0) begin bad++; $display("FAIL live_latency_e1 got=%h want=0", page_out); end
    tick();
    total++; if (page_out !== PAGE0) begin bad++; $display("FAIL live_page0 got=%h want=%h", page_out, PAGE0); end
    page_next = 1'b1;
    tick();
    page_next = 1'b0;
    total++; if (page_idx !== 1'b1) begin bad++; $display("FAIL next_idx1 got=%h want=1", page_idx); end
    tick();
    total++; if (page_out !== PAGE1) begin bad++; $display("FAIL live_page1 got=%h want=%h", page_out, PAGE1); end
    total++; if (changed !== 8'h00) begin bad++; $display("FAIL live_changed got=%h want=00", changed); end
    page_next = 1'b1;
    tick();
    page_next = 1'b0;
    total++; if (page_idx !== 1'b0) begin bad++; $display("FAIL next_wrap got=%h want=0", page_idx); end
    tick();
    total++; if (page_out !== PAGE0) begin bad++; $display("FAIL live_page0_again got=%h want=%h", page_out, PAGE0); end
  endtask

  task automatic test_autoscan();
    logic        exp_idx;
    logic [14:1] exp_pn;
    reset_main(2'd2);
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_idx = ((e / 4) % 2) == 1;
      total++; if (page_idx !== exp_idx) begin bad++; $display("FAIL scan_e%0d got=%h want=%h", e, page_idx, exp_idx); end
    end
    // Manual pulse at edge 6 restarts the scan period: next auto advance at edge 10.
    exp_pn = 14'b01111000011000;
    reset_main(2'd2);
    for (int e = 1; e <= 14; e++) begin
      page_next = (e == 6);
      tick();
      total++; if (page_idx !== exp_pn[e]) begin bad++; $display("FAIL scan_pulse_e%0d got=%h want=%h", e, page_idx, exp_pn[e]); end
    end
    page_next = 1'b0;
    // Pulse coinciding with scan expiry at edge 4 advances a single page.
    reset_main(2'd2);
    for (int e = 1; e <= 8; e++) begin
      page_next = (e == 4);
      tick();
      exp_idx = (e >= 4 && e < 8);
      total++; if (page_idx !== exp_idx) begin bad++; $display("FAIL scan_coincide_e%0d got=%h want=%h", e, page_idx, exp_idx); end
    end
    page_next = 1'b0;
  endtask

  task automatic test_freeze();
    mon_flat = BASE;
    mon_flat[23:16] = 8'hAA;
    reset_main(2'd0);
    tick();
    tick();
    mode = 2'd1;
    tick();
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL frz_snap_valid got=%b want=1", snap_valid); end
    mon_flat[23:16] = 8'h55;
    tick();
    total++; if (page_out !== 64'h1716151413AA1110) begin bad++; $display("FAIL frz_page_e4 got=%h want=1716151413aa1110", page_out); end
    total++; if (changed !== 8'h00) begin bad++; $display("FAIL frz_changed_e4 got=%h want=00", changed); end
    tick();
    total++; if (page_out !== 64'h1716151413AA1110) begin bad++; $display("FAIL frz_hold_e5 got=%h want=1716151413aa1110", page_out); end
    total++; if (changed !== 8'h04) begin bad++; $display("FAIL frz_changed_e5 got=%h want=04", changed); end
    mode = 2'd0;
    tick();
    total++; if (page_out !== 64'h1716151413551110) begin bad++; $display("FAIL unfrz_page got=%h want=1716151413551110", page_out); end
    total++; if (changed !== 8'h04) begin bad++; $display("FAIL unfrz_changed got=%h want=04", changed); end
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL unfrz_snap_valid got=%b want=1", snap_valid); end
    mode = 2'd1; snap = 1'b1; mon_flat[23:16] = 8'h77;
    tick();
    snap = 1'b0; mon_flat[23:16] = 8'h99;
    tick();
    total++; if (page_out !== 64'h1716151413771110) begin bad++; $display("FAIL resnap_page got=%h want=1716151413771110", page_out); end
    total++; if (changed !== 8'h00) begin bad++; $display("FAIL resnap_changed got=%h want=00", changed); end
    tick();
    total++; if (page_out !== 64'h1716151413771110) begin bad++; $display("FAIL resnap_hold got=%h want=1716151413771110", page_out); end
    total++; if (changed !== 8'h04) begin bad++; $display("FAIL resnap_changed2 got=%h want=04", changed); end
    mode = 2'd3;
    tick();
    total++; if (page_out !== 64'h1716151413991110) begin bad++; $display("FAIL mode3_live got=%h want=1716151413991110", page_out); end
    mode = 2'd0;
  endtask

  task automatic test_reset_mid();
    logic exp_idx;
    mon_flat = BASE;
    reset_main(2'd2);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int e = 2; e <= 5; e++) tick();
    total++; if (page_idx !== 1'b1) begin bad++; $display("FAIL mid_pre_idx got=%h want=1", page_idx); end
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_snap_valid got=%b want=1", snap_valid); end
    total++; if (page_out !== PAGE1) begin bad++; $display("FAIL mid_pre_page got=%h want=%h", page_out, PAGE1); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++; if (page_out !== 64'h0) begin bad++; $display("FAIL mid_rst_page got=%h want=0", page_out); end
    total++; if (page_idx !== 1'b0) begin bad++; $display("FAIL mid_rst_idx got=%h want=0", page_idx); end
    total++; if (changed !== 8'h00) begin bad++; $display("FAIL mid_rst_changed got=%h want=00", changed); end
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_snap_valid got=%b want=0", snap_valid); end
    for (int e = 7; e <= 10; e++) begin
      tick();
      exp_idx = (e == 10);
      total++; if (page_idx !== exp_idx) begin bad++; $display("FAIL mid_restart_e%0d got=%h want=%h", e, page_idx, exp_idx); end
    end
    mode = 2'd1; rst = 1'b0;
    tick();
    rst = 1'b1;
    total++; if (snap_valid !== 1'b0) begin bad++; $display("FAIL frz_rst_snap_valid got=%b want=0", snap_valid); end
    tick();
    total++; if (snap_valid !== 1'b1) begin bad++; $display("FAIL frz_rel_capture got=%b want=1", snap_valid); end
    total++; if (page_out !== 64'h0) begin bad++; $display("FAIL frz_rel_page_e12 got=%h want=0", page_out); end
    tick();
    total++; if (page_out !== PAGE0) begin bad++; $display("FAIL frz_rel_page_e13 got=%h want=%h", page_out, PAGE0); end
    mode = 2'd0;
  endtask

  task automatic test_edge_config();
    rst_e = 1'b0; mode_e = 2'd0; snap_e = 1'b0; page_next_e = 1'b0; mon_e = 24'hC2B1A0;
    tick();
    tick();
    rst_e = 1'b1;
    tick();
    tick();
    total++; if (page_out_e !== 64'h0000000000C2B1A0) begin bad++; $display("FAIL edge_page got=%h want=c2b1a0", page_out_e); end
    page_next_e = 1'b1;
    tick();
    total++; if (page_idx_e !== 1'b0) begin bad++; $display("FAIL edge_idx_e3 got=%h want=0", page_idx_e); end
    tick();
    total++; if (page_idx_e !== 1'b0) begin bad++; $display("FAIL edge_idx_e4 got=%h want=0", page_idx_e); end
    page_next_e = 1'b0;
    tick();
    total++; if (page_out_e !== 64'h0000000000C2B1A0) begin bad++; $display("FAIL edge_page_after got=%h want=c2b1a0", page_out_e); end
    mode_e = 2'd1;
    tick();
    total++; if (snap_valid_e !== 1'b1) begin bad++; $display("FAIL edge_snap_valid got=%b want=1", snap_valid_e); end
    mon_e = 24'h123456;
    tick();
    tick();
    total++; if (changed_e !== 8'h07) begin bad++; $display("FAIL edge_changed got=%h want=07", changed_e); end
    total++; if (page_out_e !== 64'h0000000000C2B1A0) begin bad++; $display("FAIL edge_frozen got=%h want=c2b1a0", page_out_e); end
  endtask

  initial begin
    rst = 1'b0; mon_flat = '0; mode = 2'd0; snap = 1'b0; page_next = 1'b0;
    rst_e = 1'b0; mon_e = '0; mode_e = 2'd0; snap_e = 1'b0; page_next_e = 1'b0;
    test_reset();
    test_live_paging();
    test_autoscan();
    test_freeze();
    test_reset_mid();
    test_edge_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
